// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//
// UART transmitter. It edge-detects the baud generator's square wave into a
// one-cycle bit tick and serialises each word as:
//   start (0), DATA_BITS data bits LSB first, [even parity], STOP_BITS stop (1).
// A one-word holding buffer lets the producer hand over the next word while
// the current frame is still on the line. Consecutive frames are sent with
// no idle bit between them.
//
// Parameters:
//   DATA_BITS : data bits per frame (5..9)
//   STOP_BITS : stop bits per frame (1 or 2)
//
// Compile-time option:
//   UART_TX_PARITY_EN : when defined, an even-parity bit follows the last
//                       data bit. When undefined, there is no parity state
//                       and DATA goes directly to STOP.
//
// Ports:
//   clk      : system clock, rising edge
//   rst_n    : synchronous active-low reset
//   baud_clk : baud square wave, synchronous to clk; each rising edge = 1 bit
//   tx_data  : word to send, captured on handshake
//   tx_valid : producer has a word on tx_data
//   tx_ready : holding buffer empty; handshake = tx_valid && tx_ready
//   tx       : registered serial line, idles high
//   tx_busy  : registered, high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_clk,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // Counter value while the final data bit is on the line.
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
    // Stop counter value during the final stop bit.
    localparam logic             STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

`ifdef UART_TX_PARITY_EN
    // Even parity: the XOR of all data bits.
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction
`endif

    // ---------------------------------------------------------------------
    // Declarations
    // ---------------------------------------------------------------------
    logic                 baud_q_r;
    logic                 tick_s;

    logic                 hold_full_r;
    logic [DATA_BITS-1:0] hold_data_r;
    logic                 load_s;

    state_t               state_r;
    state_t               state_nx_s;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] shift_nx_s;
    logic [CNT_W-1:0]     bit_cnt_r;
    logic [CNT_W-1:0]     bit_cnt_nx_s;
    logic                 stop_cnt_r;
    logic                 stop_cnt_nx_s;
    logic                 tx_r;
    logic                 tx_nx_s;
    logic                 busy_r;

`ifdef UART_TX_PARITY_EN
    logic                 parity_r;
`endif

    // ---------------------------------------------------------------------
    // Baud edge detection
    // ---------------------------------------------------------------------
    // baud_q resets high so a baud_clk that is already high at reset
    // release does not produce a false tick.
    assign tick_s = baud_clk & ~baud_q_r;

    // Delay baud_clk by one cycle for rising-edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            baud_q_r <= 1'b1;
        end else begin
            baud_q_r <= baud_clk;
        end
    end

    // ---------------------------------------------------------------------
    // Holding buffer
    // ---------------------------------------------------------------------
    // A load can only happen while hold_full is set, and a handshake needs
    // it clear, so the two never happen on the same edge.
    assign tx_ready = ~hold_full_r;

    // Capture a word on handshake; release the slot when the FSM loads it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_full_r <= 1'b0;
            hold_data_r <= {DATA_BITS{1'b0}};
        end else if (load_s) begin
            hold_full_r <= 1'b0;
        end else if (tx_valid && !hold_full_r) begin
            hold_full_r <= 1'b1;
            hold_data_r <= tx_data;
        end else begin
            hold_full_r <= hold_full_r;
        end
    end

    // ---------------------------------------------------------------------
    // Frame FSM
    // ---------------------------------------------------------------------
    // Next-state and next-line-value logic. Every transition is gated by tick.
    always_comb begin
        state_nx_s    = state_r;
        shift_nx_s    = shift_r;
        bit_cnt_nx_s  = bit_cnt_r;
        stop_cnt_nx_s = stop_cnt_r;
        tx_nx_s       = tx_r;
        load_s        = 1'b0;

        case (state_r)
            ST_IDLE: begin
                tx_nx_s = 1'b1;
                if (tick_s && hold_full_r) begin
                    load_s     = 1'b1;
                    shift_nx_s = hold_data_r;
                    tx_nx_s    = 1'b0;
                    state_nx_s = ST_START;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end

            ST_START: begin
                if (tick_s) begin
                    tx_nx_s      = shift_r[0];
                    bit_cnt_nx_s = CNT_ZERO;
                    state_nx_s   = ST_DATA;
                end else begin
                    state_nx_s = ST_START;
                end
            end

            // bit_cnt holds the index of the data bit currently on the line.
            ST_DATA: begin
                if (tick_s) begin
                    if (bit_cnt_r == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        tx_nx_s    = parity_r;
                        state_nx_s = ST_PARITY;
`else
                        tx_nx_s       = 1'b1;
                        stop_cnt_nx_s = 1'b0;
                        state_nx_s    = ST_STOP;
`endif
                    end else begin
                        shift_nx_s   = shift_r >> 1;
                        tx_nx_s      = shift_r[1];
                        bit_cnt_nx_s = bit_cnt_r + CNT_ONE;
                        state_nx_s   = ST_DATA;
                    end
                end else begin
                    state_nx_s = ST_DATA;
                end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick_s) begin
                    tx_nx_s       = 1'b1;
                    stop_cnt_nx_s = 1'b0;
                    state_nx_s    = ST_STOP;
                end else begin
                    state_nx_s = ST_PARITY;
                end
            end
`endif

            // A waiting word goes straight into its start bit with no gap.
            ST_STOP: begin
                if (tick_s) begin
                    if (stop_cnt_r == STOP_LAST) begin
                        if (hold_full_r) begin
                            load_s     = 1'b1;
                            shift_nx_s = hold_data_r;
                            tx_nx_s    = 1'b0;
                            state_nx_s = ST_START;
                        end else begin
                            tx_nx_s    = 1'b1;
                            state_nx_s = ST_IDLE;
                        end
                    end else begin
                        stop_cnt_nx_s = stop_cnt_r + 1'b1;
                        tx_nx_s       = 1'b1;
                        state_nx_s    = ST_STOP;
                    end
                end else begin
                    state_nx_s = ST_STOP;
                end
            end

            default: begin
                tx_nx_s    = 1'b1;
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            shift_r    <= {DATA_BITS{1'b0}};
            bit_cnt_r  <= CNT_ZERO;
            stop_cnt_r <= 1'b0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            shift_r    <= shift_nx_s;
            bit_cnt_r  <= bit_cnt_nx_s;
            stop_cnt_r <= stop_cnt_nx_s;
            tx_r       <= tx_nx_s;
            busy_r     <= (state_nx_s != ST_IDLE);
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity is taken from the whole word at load time, because the shift
    // register no longer holds every data bit when the parity bit is sent.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity_r <= 1'b0;
        end else if (load_s) begin
            parity_r <= calc_parity(hold_data_r);
        end else begin
            parity_r <= parity_r;
        end
    end
`endif

    assign tx      = tx_r;
    assign tx_busy = busy_r;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//
// Directed self-checking bench for uart_tx. It uses the default parameters
// (8 data bits, 1 stop bit). baud_clk has a period of 8 clk cycles.
// Expected line patterns are hand-computed. Bit i of each EXP_* constant is
// the i-th bit on the line, with the start bit at index 0.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int BAUD_HALF = 4;
    localparam int BAUD_CLKS = 2 * BAUD_HALF;

`ifdef UART_TX_PARITY_EN
    localparam int          FRAME_BITS = 11;
    localparam logic [15:0] EXP_A5 = 16'h054A;
    localparam logic [15:0] EXP_00 = 16'h0400;
    localparam logic [15:0] EXP_FF = 16'h05FE;
    localparam logic [15:0] EXP_11 = 16'h0422;
    localparam logic [15:0] EXP_22 = 16'h0444;
    localparam logic [15:0] EXP_33 = 16'h0466;
    localparam logic [15:0] EXP_5A = 16'h04B4;
    localparam logic [15:0] EXP_07 = 16'h060E;
    localparam logic [15:0] EXP_03 = 16'h0406;
`else
    localparam int          FRAME_BITS = 10;
    localparam logic [15:0] EXP_A5 = 16'h034A;
    localparam logic [15:0] EXP_00 = 16'h0200;
    localparam logic [15:0] EXP_FF = 16'h03FE;
    localparam logic [15:0] EXP_11 = 16'h0222;
    localparam logic [15:0] EXP_22 = 16'h0244;
    localparam logic [15:0] EXP_33 = 16'h0266;
    localparam logic [15:0] EXP_5A = 16'h02B4;
`endif

    logic       clk;
    logic       rst_n;
    logic       baud_clk;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       tx_busy;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .baud_clk (baud_clk),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx       (tx),
        .tx_busy  (tx_busy)
    );

    // System clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Baud square wave, driven on the falling clk edge.
    initial begin
        baud_clk = 1'b0;
        forever begin
            repeat (BAUD_HALF) @(negedge clk);
            baud_clk = ~baud_clk;
        end
    end

    // Guard against a hang.
    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Offer one word and wait for the handshake. Call this task at a negedge.
    task automatic send(input logic [7:0] d);
        int n = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_val("send_ready_seen", {31'd0, tx_ready}, 32'd1);
        @(negedge clk);
        check_val("ready_low_after_accept", {31'd0, tx_ready}, 32'd0);
        tx_valid = 1'b0;
    endtask

    // Wait, with a bound, for tx to go low at a negedge.
    task automatic wait_start(input string tag);
        int n = 0;
        while (tx !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_start_seen"}, {31'd0, tx}, 32'd0);
    endtask

    // Capture one frame at every negedge and check the bit pattern, the
    // duration of each bit (constant for BAUD_CLKS samples) and tx_busy.
    // When immediate is set, the start bit must begin on the very next
    // bit period. When last is set, the line must return to idle afterwards.
    task automatic check_frame(input string tag, input logic [15:0] exp,
                               input bit immediate, input bit last);
        logic [15:0] got     = 16'd0;
        logic        stable  = 1'b1;
        logic        busy_ok = 1'b1;
        if (immediate) begin
            @(negedge clk);
        end else begin
            wait_start(tag);
        end
        for (int i = 0; i < FRAME_BITS; i++) begin
            for (int c = 0; c < BAUD_CLKS; c++) begin
                if (!(i == 0 && c == 0)) @(negedge clk);
                if (c == 0) got[i] = tx;
                else if (tx !== got[i]) stable = 1'b0;
                if (tx_busy !== 1'b1) busy_ok = 1'b0;
            end
        end
        check_val({tag, "_bits"}, {16'd0, got}, {16'd0, exp});
        check_val({tag, "_bit_width"}, {31'd0, stable}, 32'd1);
        check_val({tag, "_busy_in_frame"}, {31'd0, busy_ok}, 32'd1);
        if (last) begin
            @(negedge clk);
            check_val({tag, "_busy_after"}, {31'd0, tx_busy}, 32'd0);
            check_val({tag, "_idle_after"}, {31'd0, tx}, 32'd1);
        end
    endtask

    // Check that the line stays idle for a number of clk cycles.
    task automatic check_quiet(input string tag, input int cycles);
        logic ok = 1'b1;
        repeat (cycles) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0) ok = 1'b0;
        end
        check_val(tag, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;

        // Reset held for three cycles while baud_clk keeps toggling.
        repeat (3) begin
            @(negedge clk);
            check_val("rst_tx", {31'd0, tx}, 32'd1);
            check_val("rst_ready", {31'd0, tx_ready}, 32'd1);
            check_val("rst_busy", {31'd0, tx_busy}, 32'd0);
        end
        rst_n = 1'b1;
        check_quiet("post_reset_quiet", 3 * BAUD_CLKS);

        // Single word from idle.
        fork
            send(8'hA5);
            check_frame("a5", EXP_A5, 1'b0, 1'b1);
        join

        // Back-to-back: the second word is accepted while the first is on the line.
        fork
            begin
                send(8'h00);
                send(8'hFF);
                repeat (40) @(negedge clk);
                check_val("b2b_ready_low_midframe", {31'd0, tx_ready}, 32'd0);
            end
            begin
                check_frame("b2b_00", EXP_00, 1'b0, 1'b0);
                check_frame("b2b_ff", EXP_FF, 1'b1, 1'b1);
            end
        join

`ifdef UART_TX_PARITY_EN
        // Parity bit value for an odd and an even number of ones.
        fork
            send(8'h07);
            check_frame("par_07", EXP_07, 1'b0, 1'b1);
        join
        fork
            send(8'h03);
            check_frame("par_03", EXP_03, 1'b0, 1'b1);
        join
`endif

        // Continuous valid with three words; none may be lost or reordered.
        fork
            begin
                send(8'h11);
                send(8'h22);
                send(8'h33);
            end
            begin
                check_frame("buf_11", EXP_11, 1'b0, 1'b0);
                check_frame("buf_22", EXP_22, 1'b1, 1'b0);
                check_frame("buf_33", EXP_33, 1'b1, 1'b1);
            end
        join

        // Reset in the middle of data bit 3, with a second word buffered.
        fork
            begin
                send(8'h5A);
                send(8'h77);
            end
            begin
                wait_start("mid_rst");
                repeat (4 * BAUD_CLKS + BAUD_HALF) @(negedge clk);
            end
        join
        rst_n = 1'b0;
        @(negedge clk);
        check_val("mid_rst_tx", {31'd0, tx}, 32'd1);
        check_val("mid_rst_ready", {31'd0, tx_ready}, 32'd1);
        check_val("mid_rst_busy", {31'd0, tx_busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_quiet("mid_rst_word_dropped", 4 * FRAME_BITS * BAUD_CLKS);

        // The line works normally after the reset.
        fork
            send(8'h5A);
            check_frame("after_rst_5a", EXP_5A, 1'b0, 1'b1);
        join

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter that serialises parallel bytes onto a single TX line, one bit per baud period. It sits directly downstream of the baud generator: it consumes that block's `baud_clk` square wave in the system clock domain, edge-detects it into a one-cycle bit tick, and frames each byte as start bit, data (LSB first), optional parity, and stop bit(s). A one-word holding buffer decouples the producer from the bit-level timing, so consecutive frames go out with no idle gap.

## Interface
Parameters:
- `DATA_BITS`, default 8: data bits per frame. Legal range is 5–9.
- `STOP_BITS`, default 1: stop bits per frame. Legal values are 1 or 2.

Ports:
- `clk`, input, 1: system clock. All logic is on its rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `baud_clk`, input, 1: square wave from the baud generator, synchronous to `clk`. Each rising edge marks one bit period.
- `tx_data`, input, `DATA_BITS`: byte to send. Captured on handshake.
- `tx_valid`, input, 1: the producer has data on `tx_data`.
- `tx_ready`, output, 1: the holding buffer is empty. A word is accepted on a `clk` edge where `tx_valid && tx_ready`.
- `tx`, output, 1: serial line. Registered. Idles high.
- `tx_busy`, output, 1: the FSM is not in IDLE.

## Operation
- Tick detection:
  - `baud_q` registers `baud_clk`.
  - `tick = baud_clk & ~baud_q`.
  - `baud_q` resets to 1, so no tick can occur until the first true rising edge after reset.
- Holding buffer:
  - `hold_full` sets on a handshake and clears when the FSM loads the word into the shift register.
  - `tx_ready = ~hold_full`.
  - A load and a handshake never coincide, because `tx_ready` is 0 whenever a load can occur. `tx_ready` returns to 1 on the edge after the load.
- FSM states: IDLE, START, DATA, PARITY, STOP. All transitions occur only on edges where `tick` = 1.
  - IDLE: `tx` = 1. On a tick with `hold_full` = 1: load the shift register and clear `hold_full`, set `tx` to 0, go to START.
  - START: on a tick, `tx` = shift[0], bit counter = 0, go to DATA.
  - DATA: on each tick, shift right and increment the counter. After `DATA_BITS` bits have been driven, drive parity and go to PARITY (macro defined), or drive 1 and go to STOP (macro undefined).
  - PARITY: on a tick, `tx` = 1, go to STOP.
  - STOP: count `STOP_BITS` periods. On the tick that ends the last stop bit:
    - if `hold_full` = 1, load the next word, set `tx` to 0 and go to START (back-to-back, no gap);
    - otherwise set `tx` to 1 and go to IDLE.
- Width rules:
  - The bit counter is `$clog2(DATA_BITS+1)` bits wide.
  - The stop counter is 1 bit wide.
  - The shift register is `DATA_BITS` bits wide.
- Reset, at any time including mid-frame, on the next `clk` edge:
  - `tx` = 1, `tx_ready` = 1, `tx_busy` = 0;
  - state = IDLE, `hold_full` = 0, `baud_q` = 1;
  - any frame in progress is aborted and the buffered word is discarded.

## Timing
- `tick` is high for exactly one `clk` cycle, in the cycle after `baud_clk` rises.
- `tx` changes on the `clk` edge that ends the tick cycle. That is 1 `clk` after the `baud_clk` rising edge.
- Each bit on `tx` lasts exactly one `baud_clk` period.
- Accept-to-start-bit latency from IDLE is at most one `baud_clk` period, plus 1 `clk`.
- Frame length is 1 + `DATA_BITS` + P + `STOP_BITS` bit periods, where P = 1 if parity is compiled in and 0 otherwise.
- A second word accepted during a frame is sent immediately after that frame's stop bit(s), with zero idle bits between frames.
- `tx_busy` rises on the same edge that drives the start bit. It falls on the edge that returns the FSM to IDLE.
- The producer must hold `tx_data` stable while `tx_valid` is high and `tx_ready` is low.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined: the PARITY state is included. One bit equal to the XOR of all data bits (even parity) follows the last data bit.
- Undefined: there is no PARITY state. DATA goes directly to STOP, and the frame is one bit period shorter.

## Test plan
- Reset values: hold `rst_n` = 0 for 3 `clk` cycles while `baud_clk` toggles → `tx` = 1, `tx_ready` = 1, `tx_busy` = 0 throughout, and no start bit appears.
- Single byte (8N1): send 0xA5 → `tx` per bit period reads 0,1,0,1,0,0,1,0,1,1. Each bit lasts exactly one `baud_clk` period. `tx_busy` is high for 10 periods.
- Back-to-back: send 0x00 then 0xFF, with the second word accepted mid-frame → the first frame's stop bit is followed immediately by the second frame's start bit, with no idle period. `tx_ready` is low from the second accept until the second word is loaded.
- Parity (`UART_TX_PARITY_EN` defined): send 0x07 → the parity bit is 1. Send 0x03 → the parity bit is 0. Each frame is 11 bit periods long.
- Buffer full: assert `tx_valid` continuously with 0x11, then 0x22, then 0x33 → each word is accepted only while `tx_ready` = 1, and all three appear on `tx` in order with none lost.
- Mid-frame reset: pull `rst_n` low during data bit 3 of 0x5A → `tx` = 1 on the next edge and the buffered word is dropped. After reset is released, the line stays idle until a new word is sent.
